fifo_to_axi4_wr_master: RTL

//  Parametrised AXI4 write master draining a first-word-fall-through (FWFT) FIFO into a linear DDR3 region.

---
 rtl/fifo_to_axi4_wr_master.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_to_axi4_wr_master.sv
`default_nettype none
// ============================================================================
// Module : fifo_to_axi4_wr_master
// Desc   : AXI4 INCR-burst write master draining an FWFT FIFO into a wrapping
//          DDR region. Optional macro AXI_4K_SPLIT_EN stops bursts at 4 KB.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_to_axi4_wr_master #(
  parameter int                        AXI_DATA_WIDTH = 128,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_ID         = 0,
  parameter int                        FIFO_CNT_WIDTH = 11,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BEGIN     = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_END       = 32'h0100_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8:0]                  cfg_burst_len,
  input  logic                        addr_clr,
  input  logic [AXI_DATA_WIDTH-1:0]   fifo_dout,
  input  logic                        fifo_empty,
  input  logic [FIFO_CNT_WIDTH-1:0]   fifo_rd_cnt,
  output logic                        fifo_rd_en,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic                        m_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        wr_busy,
  output logic                        burst_done,
  output logic                        resp_err,
  output logic [15:0]                 err_cnt
);

  localparam int                      c_bytes = AXI_DATA_WIDTH / 8;
  localparam int                      c_size  = $clog2(c_bytes);
  localparam logic [AXI_ID_WIDTH-1:0] c_id    = AXI_ID_WIDTH'(AXI_ID);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                    r_state, w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]                r_awlen;
  logic [7:0]                r_beat_cnt;
  logic                      r_clr_pend;
  logic [15:0]               r_err_cnt;

  logic [8:0]                w_cfg_beats, w_beats, w_len_p1;
  logic [AXI_ADDR_WIDTH:0]   w_room_bytes, w_room_beats, w_inc, w_addr_nxt;
  logic                      w_wrap, w_start, w_bhs;
`ifdef AXI_4K_SPLIT_EN
  logic [12:0]               w_room4k;
`endif

  // Beats for the next burst: clamped request, then limited by region end.
  assign w_room_bytes = {1'b0, ADDR_END} - {1'b0, r_awaddr};
  assign w_room_beats = w_room_bytes >> c_size;
`ifdef AXI_4K_SPLIT_EN
  assign w_room4k     = (13'd4096 - {1'b0, r_awaddr[11:0]}) >> c_size;
`endif

  always_comb begin
    w_cfg_beats = cfg_burst_len;
    if (cfg_burst_len == 9'd0)
      w_cfg_beats = 9'd1;
    else if (cfg_burst_len > 9'd256)
      w_cfg_beats = 9'd256;
    w_beats = w_cfg_beats;
    if (w_room_beats < {{(AXI_ADDR_WIDTH-8){1'b0}}, w_cfg_beats})
      w_beats = w_room_beats[8:0];
`ifdef AXI_4K_SPLIT_EN
    if (w_room4k < {4'd0, w_beats})
      w_beats = w_room4k[8:0];
`endif
  end

  assign w_len_p1   = {1'b0, r_awlen} + 9'd1;
  assign w_inc      = {{(AXI_ADDR_WIDTH-8){1'b0}}, w_len_p1} << c_size;
  assign w_addr_nxt = {1'b0, r_awaddr} + w_inc;
  assign w_wrap     = (w_addr_nxt >= {1'b0, ADDR_END});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // A clear in IDLE holds off the start so the next burst sizes from ADDR_BEGIN.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_bhs         = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    fifo_rd_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!addr_clr && (32'(fifo_rd_cnt) >= 32'(w_beats))) begin
          w_start     = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready)
          w_state_nxt = S_DATA;
      end
      S_DATA: begin
        m_axi_wvalid = ~fifo_empty;
        m_axi_wlast  = (r_beat_cnt == r_awlen);
        fifo_rd_en   = m_axi_wvalid & m_axi_wready;
        if (fifo_rd_en && m_axi_wlast)
          w_state_nxt = S_RESP;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          w_bhs       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awaddr   <= ADDR_BEGIN;
      r_awlen    <= 8'd0;
      r_beat_cnt <= 8'd0;
      r_clr_pend <= 1'b0;
      r_err_cnt  <= 16'd0;
    end else begin
      if (r_state == S_IDLE) begin
        if (addr_clr)
          r_awaddr <= ADDR_BEGIN;
        else if (w_start)
          r_awlen <= w_beats[7:0] - 8'd1;
      end else if (addr_clr) begin
        r_clr_pend <= 1'b1;
      end
      if (r_state == S_ADDR)
        r_beat_cnt <= 8'd0;
      else if (fifo_rd_en)
        r_beat_cnt <= r_beat_cnt + 8'd1;
      // A pending or coincident clear overrides the normal address advance.
      if (w_bhs) begin
        r_clr_pend <= 1'b0;
        if (r_clr_pend || addr_clr || w_wrap)
          r_awaddr <= ADDR_BEGIN;
        else
          r_awaddr <= w_addr_nxt[AXI_ADDR_WIDTH-1:0];
        if (resp_err && (r_err_cnt != 16'hFFFF))
          r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign resp_err      = w_bhs && ((m_axi_bresp != 2'b00) || (m_axi_bid != c_id));
  assign burst_done    = w_bhs;
  assign wr_busy       = (r_state != S_IDLE);
  assign err_cnt       = r_err_cnt;
  assign m_axi_awid    = c_id;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(c_size);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = fifo_dout;
  assign m_axi_wstrb   = '1;

endmodule
`default_nettype wire
